// File: rtl/rom_fetch_unit.sv
// +--------------------------------------------------------------------------+
// | rom_fetch_unit : PC owner and read initiator for a 1-cycle sync ROM,       |
// |                  buffering returned bytes into a valid/ready stream.       |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module rom_fetch_unit #(
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter int         FIFO_DEPTH   = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic [7:0] ROM_ADDR,
  input  logic [7:0] ROM_DATA,
  output logic [7:0] INSTR_BYTE,
  output logic [7:0] INSTR_ADDR,
  output logic       INSTR_VALID,
  input  logic       INSTR_READY,
  input  logic       JUMP_EN,
  input  logic [7:0] JUMP_ADDR,
  input  logic       HALT,
  output logic       BUSY
);

  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(FIFO_DEPTH);

  logic [7:0]         pc_q, pc_d;
  logic [7:0]         tag_q, tag_d;
  logic               inflight_q, inflight_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic [c_PTR_W-1:0] wr_q, wr_d;
  logic [c_PTR_W-1:0] rd_q, rd_d;
  logic [15:0]        fifo_q [FIFO_DEPTH];

  logic               w_pop;
  logic               w_push;
  logic               w_issue;
  logic [c_CNT_W:0]   w_credit;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign w_pop  = INSTR_VALID && INSTR_READY;
  assign w_push = inflight_q && !JUMP_EN;

  // Credit counts the buffered bytes plus the one still in the ROM pipe,
  // less the slot freed by this cycle's pop, so a push can never overflow.
  assign w_credit = {1'b0, count_q} + (c_CNT_W + 1)'(inflight_q) - (c_CNT_W + 1)'(w_pop);
  assign w_issue  = !HALT && !JUMP_EN && (w_credit < c_DEPTH);

  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    count_d    = count_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    if (JUMP_EN) begin
      pc_d    = JUMP_ADDR;
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
    end else begin
      if (w_issue) begin
        inflight_d = 1'b1;
        tag_d      = pc_q;
        pc_d       = pc_q + 8'd1;
      end
      if (w_push) wr_d = ptr_inc(wr_q);
      if (w_pop)  rd_d = ptr_inc(rd_q);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + c_CNT_W'(1);
        2'b01:   count_d = count_q - c_CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pc_q       <= RESET_VECTOR;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      if (w_push) fifo_q[wr_q] <= {tag_q, ROM_DATA};
    end
  end

  assign ROM_ADDR    = pc_q;
  assign INSTR_BYTE  = fifo_q[rd_q][7:0];
  assign INSTR_ADDR  = fifo_q[rd_q][15:8];
  assign INSTR_VALID = (count_q != '0);
  assign BUSY        = inflight_q || INSTR_VALID;

endmodule

`default_nettype wire

// File: tb/tb_rom_fetch_unit.sv
// +--------------------------------------------------------------------------+
// | tb_rom_fetch_unit : directed + random stream test with address scoreboard |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rom_fetch_unit;

  localparam logic [7:0] c_RV = 8'h00;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] ROM_ADDR;
  logic [7:0] ROM_DATA;
  logic [7:0] INSTR_BYTE;
  logic [7:0] INSTR_ADDR;
  logic       INSTR_VALID;
  logic       INSTR_READY;
  logic       JUMP_EN;
  logic [7:0] JUMP_ADDR;
  logic       HALT;
  logic       BUSY;

  logic [7:0] rom [256];

  int         total_cnt = 0;
  int         pass_cnt  = 0;
  logic [7:0] exp_addr  = c_RV;
  int         pops      = 0;
  logic       hold_chk  = 1'b0;
  logic [7:0] hold_byte = 8'h00;
  logic [7:0] hold_addr = 8'h00;

  rom_fetch_unit #(.RESET_VECTOR(c_RV), .FIFO_DEPTH(2)) dut (
    .CLK(CLK), .RESET(RESET), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
    .INSTR_BYTE(INSTR_BYTE), .INSTR_ADDR(INSTR_ADDR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .JUMP_EN(JUMP_EN), .JUMP_ADDR(JUMP_ADDR),
    .HALT(HALT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Synchronous ROM: data is the byte at the address sampled on the previous edge
  always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: scoreboard any pop about to happen, then advance to the next negedge
  task automatic tick();
    #1;
    if (RESET) begin
      if (hold_chk) begin
        chk("hold_valid", {15'd0, INSTR_VALID}, 16'd1);
        chk("hold_byte", {8'd0, INSTR_BYTE}, {8'd0, hold_byte});
        chk("hold_addr", {8'd0, INSTR_ADDR}, {8'd0, hold_addr});
      end
      if (INSTR_VALID && INSTR_READY) begin
        chk("sb_addr", {8'd0, INSTR_ADDR}, {8'd0, exp_addr});
        chk("sb_byte", {8'd0, INSTR_BYTE}, {8'd0, rom[exp_addr]});
        exp_addr = exp_addr + 8'd1;
        pops++;
      end
    end
    hold_chk  = RESET && !JUMP_EN && INSTR_VALID && !INSTR_READY;
    hold_byte = INSTR_BYTE;
    hold_addr = INSTR_ADDR;
    if (!RESET)       exp_addr = c_RV;
    else if (JUMP_EN) exp_addr = JUMP_ADDR;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic run_until_head(input logic [7:0] a, input int budget);
    int n = 0;
    while (!(INSTR_VALID && INSTR_ADDR == a) && n < budget) begin
      tick();
      n++;
    end
    chk("reach_head", {7'd0, INSTR_VALID, INSTR_ADDR}, {7'd0, 1'b1, a});
  endtask

  task automatic chk_head(input string tag, input logic [7:0] a);
    chk(tag, {7'd0, INSTR_VALID, INSTR_ADDR}, {7'd0, 1'b1, a});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hA5;
    RESET = 1'b0; INSTR_READY = 1'b1; JUMP_EN = 1'b0; JUMP_ADDR = 8'h00; HALT = 1'b0;
    @(negedge CLK);

    // Reset state
    tick();
    chk("rst_valid", {15'd0, INSTR_VALID}, 16'd0);
    chk("rst_busy", {15'd0, BUSY}, 16'd0);
    chk("rst_rom_addr", {8'd0, ROM_ADDR}, {8'd0, c_RV});
    chk("rst_byte_addr", {INSTR_BYTE, INSTR_ADDR}, 16'h0000);
    tick();
    RESET = 1'b1;

    // Two-edge latency, then one byte per cycle
    tick();
    chk("lat_edge1_valid", {15'd0, INSTR_VALID}, 16'd0);
    tick();
    chk_head("lat_edge2_head", 8'h00);
    chk("first_byte", {8'd0, INSTR_BYTE}, 16'h00A5);
    for (int i = 0; i < 16; i++) tick();
    chk_head("throughput_head", 8'h10);

    // Backpressure
    INSTR_READY = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_head("bp_head", 8'h10);
    chk("bp_rom_addr", {8'd0, ROM_ADDR}, 16'h0012);
    chk("bp_busy", {15'd0, BUSY}, 16'd1);
    INSTR_READY = 1'b1;
    run_until_head(8'h20, 40);

    // Jump flush
    JUMP_EN = 1'b1; JUMP_ADDR = 8'h80;
    tick();
    JUMP_EN = 1'b0;
    chk("jmp_valid0", {15'd0, INSTR_VALID}, 16'd0);
    tick();
    chk("jmp_valid1", {15'd0, INSTR_VALID}, 16'd0);
    tick();
    chk_head("jmp_head", 8'h80);
    chk("jmp_byte", {8'd0, INSTR_BYTE}, {8'd0, rom[8'h80]});

    // Wrap
    JUMP_EN = 1'b1; JUMP_ADDR = 8'hFE;
    tick();
    JUMP_EN = 1'b0;
    tick(); tick();
    chk_head("wrap_fe", 8'hFE);
    tick();
    chk_head("wrap_ff", 8'hFF);
    tick();
    chk_head("wrap_00", 8'h00);
    tick();
    chk_head("wrap_01", 8'h01);

    // HALT while 0x30 is in flight
    run_until_head(8'h2F, 80);
    HALT = 1'b1;
    pops = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("halt_pops", 16'(pops), 16'd2);
    chk("halt_valid", {15'd0, INSTR_VALID}, 16'd0);
    chk("halt_busy", {15'd0, BUSY}, 16'd0);
    chk("halt_rom_addr", {8'd0, ROM_ADDR}, 16'h0031);
    HALT = 1'b0;
    tick(); tick();
    chk_head("halt_resume", 8'h31);

    // Reset with a full FIFO
    INSTR_READY = 1'b0;
    tick(); tick(); tick();
    chk_head("full_head", 8'h31);
    chk("full_rom_addr", {8'd0, ROM_ADDR}, 16'h0033);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    chk("midrst_valid", {15'd0, INSTR_VALID}, 16'd0);
    chk("midrst_busy", {15'd0, BUSY}, 16'd0);
    chk("midrst_rom_addr", {8'd0, ROM_ADDR}, {8'd0, c_RV});
    INSTR_READY = 1'b1;
    tick(); tick();
    chk_head("midrst_head", c_RV);
    chk("midrst_byte", {8'd0, INSTR_BYTE}, {8'd0, rom[c_RV]});

    // Random traffic with fresh ROM contents, loaded while held in reset
    RESET = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    tick();
    RESET = 1'b1;
    for (int i = 0; i < 800; i++) begin
      INSTR_READY = ($urandom_range(0, 9) < 7);
      HALT        = ($urandom_range(0, 9) == 0);
      JUMP_EN     = ($urandom_range(0, 19) == 0);
      JUMP_ADDR   = 8'($urandom);
      RESET       = ($urandom_range(0, 99) != 0);
      tick();
    end
    RESET = 1'b1; INSTR_READY = 1'b1; HALT = 1'b0; JUMP_EN = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk_head("final_stream", exp_addr);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rom_fetch_unit.md
Name: rom_fetch_unit

Overview:
- Read-side initiator for the program ROM's synchronous read port.
- The ROM samples the 8-bit address on CLK and returns the byte on its data bus one cycle later; it has no enable and no handshake.
- This block owns the program counter and drives that address. It tracks the one-cycle read latency and buffers returned bytes in a small FIFO, presenting them to the processor core over a valid/ready stream.
- It also supports jumps, which flush any in-flight or buffered bytes.

Parameters:
- RESET_VECTOR, 8'h00, PC value loaded on reset.
- FIFO_DEPTH, 2, byte buffer entries; must be at least 2 for full throughput.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-low reset.
- ROM_ADDR  out  8  address to ROM; always equals PC (combinational from PC register).
- ROM_DATA  in  8  ROM read data; holds ROM[address sampled at previous edge].
- INSTR_BYTE  out  8  FIFO head byte.
- INSTR_ADDR  out  8  ROM address the head byte was read from.
- INSTR_VALID  out  1  FIFO non-empty.
- INSTR_READY  in  1  consumer accepts head when INSTR_VALID && INSTR_READY at an edge (pop).
- JUMP_EN  in  1  load PC from JUMP_ADDR and flush.
- JUMP_ADDR  in  8  jump target.
- HALT  in  1  level; while high, no new reads are issued.
- BUSY  out  1  inflight || INSTR_VALID.

Behaviour:
- Reset (RESET==0 at an edge):
  - PC<=RESET_VECTOR; FIFO count<=0; inflight<=0.
  - Outputs: INSTR_VALID=0, BUSY=0, ROM_ADDR=RESET_VECTOR. INSTR_BYTE and INSTR_ADDR are 8'h00.
  - Reset overrides JUMP_EN, pop and issue.
- Issue condition, evaluated each cycle:
  - issue = !HALT && !JUMP_EN && (count + inflight - pop) < FIFO_DEPTH.
  - On issue at an edge, the ROM captures ROM[PC]. Set inflight<=1 and tag<=PC, then PC<=PC+1 (mod 256, so 8'hFF wraps to 8'h00).
  - No issue: PC holds and inflight<=0. The ROM re-reads the same address harmlessly and that data is ignored.
- Return:
  - If inflight==1 at an edge, push {tag, ROM_DATA} into the FIFO.
  - The credit rule guarantees no overflow. Push and pop in the same cycle are legal; count is unchanged.
- Pop: on INSTR_VALID && INSTR_READY, the head advances.
- Latency:
  - Byte read at issue edge E is pushed at edge E+1 and visible on INSTR_* after E+1.
  - With INSTR_READY held high, one byte is delivered per cycle in address order.
- Jump (JUMP_EN==1 at an edge, RESET==1):
  - PC<=JUMP_ADDR, FIFO count<=0, inflight<=0; no issue that edge.
  - A pop in that same cycle counts as consumed.
  - First target byte: issued at the next edge, visible after 2 edges from the jump edge.
  - JUMP_EN held high for several cycles: PC reloads each cycle and nothing is issued.
- HALT:
  - Blocks issue only. An in-flight byte still lands and the FIFO still drains.
  - Deassertion resumes at the current PC with no skipped or duplicated address.
- Backpressure:
  - INSTR_READY low: the FIFO fills to FIFO_DEPTH and issue stops.
  - No byte is dropped or duplicated.
  - INSTR_BYTE and INSTR_ADDR stay stable while INSTR_VALID && !INSTR_READY.
- Reset mid-stream discards inflight and FIFO contents. The first post-reset byte is from RESET_VECTOR.

Test Plan:
- Reset then stream: ROM[i]=i^8'hA5, RESET low for 2 cycles, READY=1.
  - Expect INSTR_VALID rises 2 edges after RESET release.
  - Consecutive bytes A5,A4,A7,... with INSTR_ADDR 00,01,02,..., one per cycle.
- Backpressure: READY=0 for 5 cycles mid-stream starting at addr 10, then READY=1.
  - Expect the FIFO holds 10,11 and ROM_ADDR stays 12.
  - Resumed sequence 10,11,12,... with no gaps or duplicates.
- Jump flush: while streaming at addr 20, pulse JUMP_EN with JUMP_ADDR=8'h80.
  - Expect INSTR_VALID low after the jump edge.
  - Next byte ROM[80] with INSTR_ADDR=80 two edges later; no addr 21/22 bytes ever delivered.
- Wrap: JUMP_ADDR=8'hFE, READY=1.
  - Expect INSTR_ADDR sequence FE,FF,00,01.
- HALT: assert HALT at addr 30 for 4 cycles, READY=1.
  - Expect at most one more byte (30), then INSTR_VALID=0 and BUSY=0.
  - After release, next byte is at addr 31.
- Reset mid-operation: FIFO full with READY=0, assert RESET one cycle.
  - Expect INSTR_VALID=0 next cycle; stream restarts at RESET_VECTOR.
